nios2_div_cell: RTL and testbench

NIOS2_DIV_CELL -- requirements
Module: nios2_div_cell

---
 rtl/nios2_div_pkg.sv | 18 +
 rtl/nios2_div_step.sv | 34 +++
 rtl/nios2_div_cell.sv | 167 ++++++++++++++++
 tb/tb_nios2_div_cell.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nios2_div_pkg.sv
// rtl/nios2_div_pkg.sv - shared types and constants for the iterative divider
//
// Holds the divider FSM state encoding, the default operand width and the
// quotient returned for a zero divisor.
package nios2_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } div_state_e;

    // Quotient produced for any divide by zero, signed or unsigned.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/nios2_div_step.sv
// rtl/nios2_div_step.sv - one combinational radix-2 restoring division step
//
// Ports:
//   rem_i     : partial remainder before the step
//   quo_i     : partial quotient / remaining dividend bits before the step
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after the step
//   quo_o     : partial quotient after the step (new bit in LSB)
module nios2_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           negative;

    // {rem,quo} shifted left by one; the remainder half keeps its carried-out
    // MSB so the trial subtract sees the full WIDTH+1-bit value.
    assign shifted  = {rem_i, quo_i[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor_i};
    assign negative = diff[WIDTH];

    // Restore on a negative trial result. The restored value is always below
    // the divisor, so its top bit is zero and WIDTH bits suffice.
    assign rem_o = negative ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~negative};

endmodule

// File: rtl/nios2_div_cell.sv
// rtl/nios2_div_cell.sv - fixed-latency 32-bit signed/unsigned divide cell
//
// Ports:
//   clk, reset_n       : clock and synchronous active-low reset
//   M_div_src1         : dividend
//   M_div_src2         : divisor
//   M_div_signed       : 1 = two's-complement divide, 0 = unsigned
//   M_div_rem_sel      : 1 = return remainder, 0 = return quotient
//   M_div_start        : start request, honoured only in IDLE
//   M_div_busy         : operation in progress (CALC and FIXUP)
//   M_div_done         : one-cycle pulse while the result is valid
//   M_div_cell_result  : selected quotient or remainder, held until next op
module nios2_div_cell
    import nios2_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    input  logic             M_div_signed,
    input  logic             M_div_rem_sel,
    input  logic             M_div_start,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_cell_result
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             rem_sel_q, rem_sel_d;
    logic             div_zero_q, div_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    nios2_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Sign fixup is applied to the outputs of the final step so the result
    // can be registered on the same edge that enters FIXUP. A zero divisor
    // bypasses the arithmetic: all-ones quotient, original dividend as
    // remainder, independent of signedness.
    assign quo_fixed = div_zero_q ? WIDTH'(DIV0_QUOT)
                                  : (quo_neg_q ? -step_quo : step_quo);
    assign rem_fixed = div_zero_q ? dvd_q
                                  : (rem_neg_q ? -step_rem : step_rem);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            dvd_q      <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            rem_sel_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            dvd_q      <= dvd_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            rem_sel_q  <= rem_sel_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (M_div_start) state_d = ST_CALC;
            ST_CALC:  if (cnt_q == '0) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        rem_sel_d  = rem_sel_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;
        // busy covers CALC and FIXUP; done is high exactly while in FIXUP.
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FIXUP);

        case (state_q)
            ST_IDLE: begin
                if (M_div_start) begin
                    dvd_d      = M_div_src1;
                    quo_d      = magnitude(M_div_src1, M_div_signed);
                    dvs_d      = magnitude(M_div_src2, M_div_signed);
                    rem_d      = '0;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    quo_neg_d  = M_div_signed & (M_div_src1[WIDTH-1] ^ M_div_src2[WIDTH-1]);
                    rem_neg_d  = M_div_signed & M_div_src1[WIDTH-1];
                    rem_sel_d  = M_div_rem_sel;
                    div_zero_d = (M_div_src2 == '0);
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    result_d = rem_sel_q ? rem_fixed : quo_fixed;
                end
            end
            default: begin
            end
        endcase
    end

    assign M_div_busy        = busy_q;
    assign M_div_done        = done_q;
    assign M_div_cell_result = result_q;

endmodule

// File: tb/tb_nios2_div_cell.sv
// tb/tb_nios2_div_cell.sv - self-checking bench for nios2_div_cell
module tb_nios2_div_cell;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        sgn = 1'b0;
    logic        rsel = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int          n_cmp = 0;
    int          n_fail = 0;

    // Reference timeline: cycles elapsed since an accepted start (0 = idle).
    int          cyc_m = 0;
    logic [31:0] pend = '0;
    logic [31:0] exp_res = '0;
    logic [31:0] got;

    always #5 clk = ~clk;

    nios2_div_cell #(
        .WIDTH(32)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .M_div_src1        (src1),
        .M_div_src2        (src2),
        .M_div_signed      (sgn),
        .M_div_rem_sel     (rsel),
        .M_div_start       (start),
        .M_div_busy        (busy),
        .M_div_done        (done),
        .M_div_cell_result (res)
    );

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic r);
        logic [31:0] q;
        logic [31:0] m;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            m = a;
        end else if (!s) begin
            q = a / b;
            m = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            m = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            m = $signed(a) % $signed(b);
        end
        return r ? m : q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: update the timeline model from the inputs presented at the
    // edge, then compare busy/done/result against it.
    task automatic tick();
        logic        st_in;
        logic        rn_in;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        r;
        st_in = start;
        rn_in = reset_n;
        a = src1;
        b = src2;
        s = sgn;
        r = rsel;
        @(posedge clk);
        #1;
        if (!rn_in) begin
            cyc_m   = 0;
            exp_res = '0;
        end else if (cyc_m == 0) begin
            if (st_in) begin
                cyc_m = 1;
                pend  = ref_div(a, b, s, r);
            end
        end else if (cyc_m == 33) begin
            cyc_m = 0;
        end else begin
            cyc_m++;
        end
        if (cyc_m == 33) exp_res = pend;
        check("busy", {31'd0, busy}, {31'd0, cyc_m != 0});
        check("done", {31'd0, done}, {31'd0, cyc_m == 33});
        check("result", res, exp_res);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic r, output logic [31:0] result);
        int n;
        src1  = a;
        src2  = b;
        sgn   = s;
        rsel  = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, 33);
        result = res;
        tick();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;

        // Reset
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_res", res, 32'd0);
        reset_n = 1'b1;
        tick();

        // Directed arithmetic
        run_op(32'd100, 32'd7, 1'b0, 1'b0, got);
        check("u_quo", got, 32'd14);
        run_op(32'd100, 32'd7, 1'b0, 1'b1, got);
        check("u_rem", got, 32'd2);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, got);
        check("s_quo", got, 32'hFFFF_FFF2);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, got);
        check("s_rem", got, 32'hFFFF_FFFE);
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, got);
        check("u_div0_quo", got, 32'hFFFF_FFFF);
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b1, got);
        check("u_div0_rem", got, 32'h1234_5678);
        run_op(32'h8765_4321, 32'd0, 1'b1, 1'b0, got);
        check("s_div0_quo", got, 32'hFFFF_FFFF);
        run_op(32'h8765_4321, 32'd0, 1'b1, 1'b1, got);
        check("s_div0_rem", got, 32'h8765_4321);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, got);
        check("ovf_quo", got, 32'h8000_0000);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, got);
        check("ovf_rem", got, 32'd0);

        // Start held high: ignored while busy and in the done cycle,
        // accepted again on the following cycle. Operands churn mid-op.
        src1  = 32'd1000;
        src2  = 32'd3;
        sgn   = 1'b0;
        rsel  = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (i == 33) check("hs_first", res, 32'd333);
            if (i < 35) begin
                src1 = $urandom;
                src2 = $urandom_range(1, 50);
                sgn  = 1'($urandom_range(0, 1));
                rsel = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        for (int i = 0; i < 40 && cyc_m != 0; i++) tick();
        check("hs_idle_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of CALC
        run_op(32'd50, 32'd5, 1'b0, 1'b0, got);
        src1  = 32'h1234_5678;
        src2  = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset_n = 1'b0;
        tick();
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_res", res, 32'd0);
        reset_n = 1'b1;
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, got);
        check("post_rst_quo", got, 32'h0FFF_FFFF);

        // Randomised operands against the reference model
        for (int k = 0; k < 1500; k++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 16);
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
